grid_env: RTL and testbench
===========================

# grid_env

Environment stage that closes the DQN training loop. It holds the 3x3 grid-world state and accepts a 2-bit action from the action determiner through a valid/ready handshake. It returns the current state `st`, next state `st1`, a signed Q8.8 reward and a terminal flag to the action determiner and the backward pass. It also owns the step and episode counters that the control unit sequences on.

## Interface
Parameters:
- START_STATE, 0, state loaded at reset and at every episode restart (0..8)
- GOAL_STATE, 8, terminal state with positive reward (0..8)
- TRAP_STATE, 4, terminal state with negative reward (0..8, must differ from GOAL_STATE)
- MAX_STEPS, 15, moves per episode before forced termination (1..15)
- R_GOAL, 16'sh0100, reward on entering the goal (+1.0)
- R_TRAP, 16'shFF00, reward on entering the trap (-1.0)
- R_WALL, 16'shFF80, reward when a move hits the grid edge (-0.5)
- R_STEP, 16'shFFF0, reward for any other move (-0.0625)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low
- act_valid  in  1  action offered
- act  in  2  action: 0 up, 1 right, 2 down, 3 left
- act_ready  out  1  environment can accept an action
- st  out  4  current state (0..8)
- st1  out  4  next state from the last move
- reward  out  16  signed Q8.8 reward from the last move
- done  out  1  last move ended the episode
- res_valid  out  1  one-cycle pulse: st1/reward/done are fresh
- step  out  4  moves completed in the current episode
- episode  out  12  completed-episode count

## Operation
- Grid coordinates: row = s/3, col = s%3.
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - A move leaving the grid keeps st1 = st.
- Reward priority, first match wins:
  - st1 == GOAL_STATE gives R_GOAL.
  - st1 == TRAP_STATE gives R_TRAP.
  - Edge hit gives R_WALL.
  - Otherwise R_STEP.
- done = (st1 == GOAL_STATE) | (st1 == TRAP_STATE) | (step == MAX_STEPS-1).
- FSM states:
  - IDLE: act_ready = 1. On act_valid & act_ready, latch act and go to MOVE.
  - MOVE: act_ready = 0. Compute st1, reward and done into registers; go to RESULT.
  - RESULT: res_valid = 1 for this single cycle. Then go to IDLE.
- On RESULT exit:
  - If done: st <= START_STATE, step <= 0, episode <= episode+1 (12-bit wrap, 4095 -> 0).
  - Else: st <= st1, step <= step+1.
- st1, reward and done hold their values until the next RESULT. done is meaningful only while res_valid is high or until the next RESULT.
- act_valid is ignored whenever act_ready is 0. No queuing, no error flag.
- Reset values (while rst = 0):
  - st = st1 = START_STATE; reward = 0; done = 0; res_valid = 0.
  - act_ready = 0; step = 0; episode = 0; FSM = IDLE.
- Reset asserted in any state, including mid-MOVE or RESULT, aborts the move. No counter update and no res_valid pulse.
- An illegal state register value (9..15) is never produced. The FSM's unused encodings return to IDLE.

## Timing
- Handshake accepted at edge E0 (IDLE, act_valid = 1).
- Edge E1: MOVE results registered; res_valid high from E1 to E2.
- Edge E2: st, step and episode updated; act_ready high again from E2.
- Latency: action to result is 1 cycle; action to updated st is 2 cycles. Throughput is one action per 3 cycles.
- act_ready rises on the first edge after rst is released.

## Test plan
- Reset then right, right, down, down from state 0 with act_valid held high:
  - st1 sequence 1, 2, 5, 8.
  - rewards FFF0, FFF0, FFF0, 0100; done only on the 4th.
  - st returns to 0, step = 0, episode = 1; res_valid pulses exactly 4 times, 3 cycles apart.
- Action up from state 0 (wall): st1 = 0, reward = FF80, done = 0, step becomes 1.
- From state 1, action down: st1 = 4 (trap), reward = FF00, done = 1, next st = 0, episode increments.
- Fifteen consecutive left moves from state 0:
  - every reward FF80.
  - done = 1 only on the 15th move, then step = 0 and episode += 1.
- Pulse act_valid during MOVE/RESULT with a different act: ignored; the result reflects only the accepted act, and act_ready is low during both cycles.
- Assert rst during MOVE:
  - no res_valid; st = 0, step = 0, episode = 0.
  - act_ready returns one cycle after release.
  - A subsequent right move gives st1 = 1.
- Force episode to 4095 (4096 goal episodes): the next completion wraps it to 0.

Source files
------------

// File: rtl/grid_env.sv
// 3x3 grid-world environment for the DQN loop: accepts one action per
// valid/ready handshake, returns st/st1/reward/done and tracks step/episode counts.
module grid_env #(
  parameter int                 START_STATE = 0,
  parameter int                 GOAL_STATE  = 8,
  parameter int                 TRAP_STATE  = 4,
  parameter int                 MAX_STEPS   = 15,
  parameter logic signed [15:0] R_GOAL      = 16'sh0100,
  parameter logic signed [15:0] R_TRAP      = 16'shFF00,
  parameter logic signed [15:0] R_WALL      = 16'shFF80,
  parameter logic signed [15:0] R_STEP      = 16'shFFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        act_valid,
  input  logic [1:0]  act,
  output logic        act_ready,
  output logic [3:0]  st,
  output logic [3:0]  st1,
  output logic [15:0] reward,
  output logic        done,
  output logic        res_valid,
  output logic [3:0]  step,
  output logic [11:0] episode
);

  // Handshake: an action transfers on a rising edge where act_valid and
  // act_ready are both high; act_valid is ignored while act_ready is low.

  localparam logic [3:0] START     = 4'(START_STATE);
  localparam logic [3:0] GOAL      = 4'(GOAL_STATE);
  localparam logic [3:0] TRAP      = 4'(TRAP_STATE);
  localparam logic [3:0] LAST_STEP = 4'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    RESULT = 2'd2
  } fsm_t;

  fsm_t        fsm;
  logic [1:0]  act_q;
  logic [1:0]  row;
  logic [1:0]  col;
  logic [3:0]  nxt;
  logic        wall;
  logic [15:0] rew_n;
  logic        done_n;

  // Row/column decode of the current cell; illegal encodings never occur.
  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (st)
      4'd0: begin row = 2'd0; col = 2'd0; end
      4'd1: begin row = 2'd0; col = 2'd1; end
      4'd2: begin row = 2'd0; col = 2'd2; end
      4'd3: begin row = 2'd1; col = 2'd0; end
      4'd4: begin row = 2'd1; col = 2'd1; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: begin row = 2'd2; col = 2'd0; end
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: begin row = 2'd0; col = 2'd0; end
    endcase
  end

  // A move off the edge leaves the agent in place and is flagged as a wall hit.
  always_comb begin
    nxt  = st;
    wall = 1'b0;
    case (act_q)
      2'd0: if (row == 2'd0) wall = 1'b1; else nxt = st - 4'd3;
      2'd1: if (col == 2'd2) wall = 1'b1; else nxt = st + 4'd1;
      2'd2: if (row == 2'd2) wall = 1'b1; else nxt = st + 4'd3;
      default: if (col == 2'd0) wall = 1'b1; else nxt = st - 4'd1;
    endcase
  end

  always_comb begin
    rew_n = R_STEP;
    if (nxt == GOAL)      rew_n = R_GOAL;
    else if (nxt == TRAP) rew_n = R_TRAP;
    else if (wall)        rew_n = R_WALL;
    done_n = (nxt == GOAL) || (nxt == TRAP) || (step == LAST_STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm       <= IDLE;
      act_q     <= 2'd0;
      act_ready <= 1'b0;
      st        <= START;
      st1       <= START;
      reward    <= 16'd0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      step      <= 4'd0;
      episode   <= 12'd0;
    end else begin
      case (fsm)
        IDLE: begin
          if (act_valid && act_ready) begin
            act_q     <= act;
            act_ready <= 1'b0;
            fsm       <= MOVE;
          end else begin
            act_ready <= 1'b1;
          end
        end
        MOVE: begin
          st1       <= nxt;
          reward    <= rew_n;
          done      <= done_n;
          res_valid <= 1'b1;
          fsm       <= RESULT;
        end
        RESULT: begin
          res_valid <= 1'b0;
          act_ready <= 1'b1;
          fsm       <= IDLE;
          if (done) begin
            st      <= START;
            step    <= 4'd0;
            episode <= episode + 12'd1;
          end else begin
            st   <= st1;
            step <= step + 4'd1;
          end
        end
        default: begin
          fsm       <= IDLE;
          act_ready <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_env.sv
// Randomized bench for grid_env: a coordinate-level grid model predicts every
// move; a scoreboard queue holds the expected {st1, reward, done} per accepted action.
module tb_grid_env;

  logic        clk;
  logic        rst;
  logic        act_valid;
  logic [1:0]  act;
  logic        act_ready;
  logic [3:0]  st;
  logic [3:0]  st1;
  logic [15:0] reward;
  logic        done;
  logic        res_valid;
  logic [3:0]  step;
  logic [11:0] episode;

  grid_env dut (
    .clk       (clk),
    .rst       (rst),
    .act_valid (act_valid),
    .act       (act),
    .act_ready (act_ready),
    .st        (st),
    .st1       (st1),
    .reward    (reward),
    .done      (done),
    .res_valid (res_valid),
    .step      (step),
    .episode   (episode)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pulses = 0;
  always @(negedge clk) if (res_valid === 1'b1) pulses <= pulses + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int m_st = 0;
  int m_step = 0;
  int m_ep = 0;
  int moves = 0;
  bit gap_on = 0;
  bit have_last = 0;
  int last_res = 0;

  task automatic model_predict(input int a, output int s1, output logic [15:0] r, output bit d);
    int row, col;
    bit hit;
    row = m_st / 3;
    col = m_st % 3;
    hit = 0;
    case (a)
      0: if (row == 0) hit = 1; else row = row - 1;
      1: if (col == 2) hit = 1; else col = col + 1;
      2: if (row == 2) hit = 1; else row = row + 1;
      default: if (col == 0) hit = 1; else col = col - 1;
    endcase
    s1 = row * 3 + col;
    if (s1 == 8)      r = 16'h0100;
    else if (s1 == 4) r = 16'hFF00;
    else if (hit)     r = 16'hFF80;
    else              r = 16'hFFF0;
    d = (s1 == 8) || (s1 == 4) || (m_step == 14);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (act_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_move(input logic [1:0] a, input bit noise);
    int s1;
    logic [15:0] r;
    bit d;
    logic [20:0] e;
    int old_st;
    wait_ready();
    if (act_ready !== 1'b1) begin
      check("ready_timeout", {31'd0, act_ready}, 32'd1);
      return;
    end
    model_predict(a, s1, r, d);
    exp_q.push_back({4'(s1), r, d});
    old_st = m_st;
    act_valid = 1'b1;
    act = a;
    @(negedge clk);  // MOVE
    act_valid = noise;
    act = a ^ 2'd2;
    check("move_ready", {31'd0, act_ready}, 32'd0);
    check("move_rv", {31'd0, res_valid}, 32'd0);
    @(negedge clk);  // RESULT
    act_valid = noise;
    act = ~a;
    check("res_rv", {31'd0, res_valid}, 32'd1);
    check("res_ready", {31'd0, act_ready}, 32'd0);
    e = exp_q.pop_front();
    check("st1", {28'd0, st1}, {28'd0, e[20:17]});
    check("reward", {16'd0, reward}, {16'd0, e[16:1]});
    check("done", {31'd0, done}, {31'd0, e[0]});
    check("st_hold", {28'd0, st}, 32'(old_st));
    if (gap_on && have_last) check("res_gap", 32'(cyc - last_res), 32'd3);
    have_last = 1;
    last_res = cyc;
    @(negedge clk);  // back in IDLE
    act_valid = 1'b0;
    moves++;
    if (d) begin
      m_st = 0;
      m_step = 0;
      m_ep = (m_ep + 1) % 4096;
    end else begin
      m_st = s1;
      m_step = m_step + 1;
    end
    check("st", {28'd0, st}, 32'(m_st));
    check("step", {28'd0, step}, 32'(m_step));
    check("episode", {20'd0, episode}, 32'(m_ep));
    check("idle_rv", {31'd0, res_valid}, 32'd0);
    check("idle_ready", {31'd0, act_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    act_valid = 1'b1;
    act = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_st", {28'd0, st}, 32'd0);
    check("rst_st1", {28'd0, st1}, 32'd0);
    check("rst_reward", {16'd0, reward}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rv", {31'd0, res_valid}, 32'd0);
    check("rst_ready", {31'd0, act_ready}, 32'd0);
    check("rst_step", {28'd0, step}, 32'd0);
    check("rst_episode", {20'd0, episode}, 32'd0);
    act_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, act_ready}, 32'd1);

    // right, right, down, down to the goal, back-to-back
    gap_on = 1;
    do_move(2'd1, 0);
    do_move(2'd1, 0);
    do_move(2'd2, 0);
    do_move(2'd2, 0);
    gap_on = 0;
    check("goal_pulses", 32'(pulses), 32'd4);
    check("goal_episode", {20'd0, episode}, 32'd1);

    // wall hit from 0, then right to 1 and down into the trap
    do_move(2'd0, 0);
    check("wall_step", {28'd0, step}, 32'd1);
    do_move(2'd1, 0);
    do_move(2'd2, 0);
    check("trap_episode", {20'd0, episode}, 32'd2);

    // fifteen left moves end the episode by step limit
    for (int i = 0; i < 15; i++) do_move(2'd3, 1);
    check("limit_episode", {20'd0, episode}, 32'd3);

    // random walk with ignored act_valid noise
    for (int i = 0; i < 200; i++)
      do_move(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // reset in the middle of a move
    wait_ready();
    act_valid = 1'b1;
    act = 2'd1;
    @(negedge clk);  // MOVE
    act_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_rv", {31'd0, res_valid}, 32'd0);
    check("abort_st", {28'd0, st}, 32'd0);
    check("abort_step", {28'd0, step}, 32'd0);
    check("abort_episode", {20'd0, episode}, 32'd0);
    check("abort_ready", {31'd0, act_ready}, 32'd0);
    rst = 1'b1;
    m_st = 0;
    m_step = 0;
    m_ep = 0;
    @(negedge clk);
    check("abort_ready_back", {31'd0, act_ready}, 32'd1);
    check("abort_no_pulse", 32'(pulses), 32'(moves));
    do_move(2'd1, 0);

    // 4096 trap episodes wrap the episode counter
    do_move(2'd2, 0);
    for (int i = 0; i < 4095; i++) begin
      do_move(2'd1, 0);
      do_move(2'd2, 0);
    end
    check("episode_wrap", {20'd0, episode}, 32'd0);
    check("total_pulses", 32'(pulses), 32'(moves));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
